// File: rtl/float_signed_round_pipe.sv
// float_signed_round_pipe: converts an unbiased FloatSigned operand to a packed IEEE-style Float
// through a two-stage valid/ready pipeline, rounding to nearest-even with per-result and sticky flags.
module float_signed_round_pipe #(
    parameter int SIGNED_EXP  = 6,
    parameter int SIGNED_FRAC = 14,
    parameter int EXP         = 5,
    parameter int FRAC        = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic                   in_isInf,
    input  logic                   in_isZero,
    input  logic [SIGNED_EXP-1:0]  in_exponent,
    input  logic [SIGNED_FRAC-1:0] in_fraction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP+FRAC:0]      out_data,
    output logic                   out_inexact,
    output logic                   out_overflow,
    output logic                   out_underflow,
    input  logic                   flag_clear,
    output logic                   sticky_inexact,
    output logic                   sticky_overflow,
    output logic                   sticky_underflow
);
    localparam int EW = (SIGNED_EXP > EXP ? SIGNED_EXP : EXP) + 2;
    localparam int AW = FRAC + 2;
    localparam int WW = SIGNED_FRAC + 1 + AW;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP) - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] SMAX = EW'(AW);

    logic                 s1Valid, s1Sign, s1Inf, s1Zero, s1Sticky;
    logic signed [EW-1:0] s1Exp;
    logic [AW-1:0]        s1Align;
    logic                 s2Valid, advance;
    logic signed [EW-1:0] biasedExp, rawShift, shiftAmt, resExp;
    logic [WW-1:0]        shifted;
    logic [FRAC+1:0]      rounded;
    logic                 roundUp, inexact, overflow;
    logic [EXP+FRAC:0]    nextData;
    logic                 nextInexact, nextOverflow, nextUnderflow, fire;

    assign advance   = !s2Valid || out_ready;
    assign in_ready  = !reset && (!s1Valid || advance);
    assign out_valid = s2Valid;
    assign fire      = s2Valid && out_ready;

    // Denormal inputs shift right past the hidden bit; the wide zero tail keeps every shifted-out bit for sticky.
    always_comb begin
        biasedExp = {{(EW-SIGNED_EXP){in_exponent[SIGNED_EXP-1]}}, in_exponent} + BIAS;
        rawShift  = (biasedExp < ONE) ? ONE - biasedExp : '0;
        shiftAmt  = (rawShift > SMAX) ? SMAX : rawShift;
        shifted   = {1'b1, in_fraction, {AW{1'b0}}} >> shiftAmt;
    end

    // Carry out of the rounded mantissa, or a denormal growing a hidden bit, bumps the exponent.
    always_comb begin
        roundUp       = s1Align[0] && (s1Sticky || s1Align[1]);
        rounded       = {1'b0, s1Align[AW-1:1]} + {{(FRAC+1){1'b0}}, roundUp};
        resExp        = s1Exp + {{(EW-1){1'b0}}, rounded[FRAC+1] || (!s1Align[AW-1] && rounded[FRAC])};
        inexact       = s1Align[0] || s1Sticky;
        overflow      = resExp >= EMAX;
        nextData      = s1Inf ? {s1Sign, {EXP{1'b1}}, {FRAC{1'b0}}} :
                        s1Zero ? {s1Sign, {(EXP+FRAC){1'b0}}} :
                        overflow ? {s1Sign, {EXP{1'b1}}, {FRAC{1'b0}}} :
                        {s1Sign, resExp[EXP-1:0], rounded[FRAC-1:0]};
        nextInexact   = !s1Inf && !s1Zero && (overflow || inexact);
        nextOverflow  = !s1Inf && !s1Zero && overflow;
        nextUnderflow = !s1Inf && !s1Zero && !overflow && inexact && (resExp == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid          <= 1'b0;
            s1Sign           <= 1'b0;
            s1Inf            <= 1'b0;
            s1Zero           <= 1'b0;
            s1Sticky         <= 1'b0;
            s1Exp            <= '0;
            s1Align          <= '0;
            s2Valid          <= 1'b0;
            out_data         <= '0;
            out_inexact      <= 1'b0;
            out_overflow     <= 1'b0;
            out_underflow    <= 1'b0;
            sticky_inexact   <= 1'b0;
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
        end else begin
            if (in_ready) begin
                s1Valid <= in_valid;
                if (in_valid) begin
                    s1Sign   <= in_sign;
                    s1Inf    <= in_isInf;
                    s1Zero   <= in_isZero;
                    s1Exp    <= (biasedExp < ONE) ? '0 : biasedExp;
                    s1Align  <= shifted[WW-1 -: AW];
                    s1Sticky <= |shifted[WW-AW-1:0];
                end
            end
            if (advance) begin
                s2Valid <= s1Valid;
                if (s1Valid) begin
                    out_data      <= nextData;
                    out_inexact   <= nextInexact;
                    out_overflow  <= nextOverflow;
                    out_underflow <= nextUnderflow;
                end
            end
            sticky_inexact   <= (fire && out_inexact) || (sticky_inexact && !flag_clear);
            sticky_overflow  <= (fire && out_overflow) || (sticky_overflow && !flag_clear);
            sticky_underflow <= (fire && out_underflow) || (sticky_underflow && !flag_clear);
        end
    end
endmodule
